// File: rtl/integral_image_builder.sv
// Streams a raster-order 4-bit frame and writes its summed-area image, one
// word per accepted pixel, using a one-row line buffer of the previous row's II.
module integral_image_builder #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int PIX_W     = 4,
    parameter int II_W      = 20,
    parameter int ADDR_W    = 15
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [II_W-1:0]   wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int COL_W = $clog2(II_WIDTH);
    localparam int ROW_W = $clog2(II_HEIGHT);
    localparam int RS_W  = $clog2(II_WIDTH * ((1 << PIX_W) - 1) + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [COL_W-1:0]    col_ctr_r;
    logic [ROW_W-1:0]    row_ctr_r;
    logic [ADDR_W-1:0]   addr_ctr_r;
    logic [RS_W-1:0]     row_sum_r;
    logic [II_W-1:0]     line_buf_r [II_WIDTH];

    logic                accept_s;
    logic                col_last_s;
    logic                row_last_s;
    logic                last_pix_s;
    logic [RS_W-1:0]     row_sum_new_s;
    logic [II_W-1:0]     above_s;
    logic [II_W-1:0]     ii_s;

    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [II_W-1:0]     wr_data_r;
    logic                busy_r;
    logic                frame_done_r;
    logic                overrun_r;

    // Pixel acceptance and the integral datapath for the current pixel
    always_comb begin
        accept_s      = (state_r == ST_ACCUM) && pix_valid && !frame_start;
        col_last_s    = (col_ctr_r == COL_W'(II_WIDTH - 1));
        row_last_s    = (row_ctr_r == ROW_W'(II_HEIGHT - 1));
        last_pix_s    = col_last_s && row_last_s;
        row_sum_new_s = RS_W'(pix_data);
        above_s       = {II_W{1'b0}};
        if (col_ctr_r != {COL_W{1'b0}}) begin
            row_sum_new_s = row_sum_r + RS_W'(pix_data);
        end else begin
            row_sum_new_s = RS_W'(pix_data);
        end
        // Row 0 never reads the buffer, so stale data from an earlier frame is harmless
        if (row_ctr_r != {ROW_W{1'b0}}) begin
            above_s = line_buf_r[col_ctr_r];
        end else begin
            above_s = {II_W{1'b0}};
        end
        ii_s = above_s + II_W'(row_sum_new_s);
    end

    // Next-state logic; frame_start restarts from any state
    always_comb begin
        state_nxt_s = state_r;
        if (frame_start) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_ACCUM: begin
                    if (accept_s && last_pix_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Column/row/address counters and running row sum
    always_ff @(posedge clk_vga) begin
        if (rst || frame_start) begin
            col_ctr_r  <= {COL_W{1'b0}};
            row_ctr_r  <= {ROW_W{1'b0}};
            addr_ctr_r <= {ADDR_W{1'b0}};
            row_sum_r  <= {RS_W{1'b0}};
        end else if (accept_s) begin
            row_sum_r  <= row_sum_new_s;
            addr_ctr_r <= last_pix_s ? {ADDR_W{1'b0}} : addr_ctr_r + ADDR_W'(1'b1);
            if (col_last_s) begin
                col_ctr_r <= {COL_W{1'b0}};
                row_ctr_r <= row_last_s ? {ROW_W{1'b0}} : row_ctr_r + ROW_W'(1'b1);
            end else begin
                col_ctr_r <= col_ctr_r + COL_W'(1'b1);
            end
        end
    end

    // Line buffer: read-before-write, so the read above sees the previous row
    always_ff @(posedge clk_vga) begin
        if (accept_s && !rst) begin
            line_buf_r[col_ctr_r] <= ii_s;
        end
    end

    // Registered memory write port and status outputs
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {ADDR_W{1'b0}};
            wr_data_r    <= {II_W{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            wr_en_r      <= accept_s;
            frame_done_r <= accept_s && last_pix_s;
            busy_r       <= (state_nxt_s == ST_ACCUM);
            if (accept_s) begin
                wr_addr_r <= addr_ctr_r;
                wr_data_r <= ii_s;
            end
            if (frame_start) begin
                overrun_r <= 1'b0;
            end else if (pix_valid && (state_r != ST_ACCUM)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed-sequence bench with random pixel data; expected II values come from
// an inclusion-exclusion reference built over the whole frame array.
module tb_integral_image_builder;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [3:0]  pix_data;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [19:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    integral_image_builder dut (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk_vga = ~clk_vga;

    int frame_pix [N];
    int exp_ii    [N];
    int wq_addr [$];
    int wq_data [$];
    int wq_done [$];
    int done_cnt = 0;
    int q_base;
    int done_base;
    int passed = 0;
    int total  = 0;

    // Write monitor, sampled on the falling edge
    always @(negedge clk_vga) begin
        if (wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            wq_done.push_back(int'(frame_done));
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    // II[y][x] = p + II[y-1][x] + II[y][x-1] - II[y-1][x-1]
    function automatic void build_model();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int v;
                v = frame_pix[y*W + x];
                if (y > 0) v += exp_ii[(y-1)*W + x];
                if (x > 0) v += exp_ii[y*W + x - 1];
                if (x > 0 && y > 0) v -= exp_ii[(y-1)*W + x - 1];
                exp_ii[y*W + x] = v;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic mark();
        q_base    = wq_addr.size();
        done_base = done_cnt;
    endtask

    task automatic start_frame(input bit with_pix);
        frame_start = 1'b1;
        pix_valid   = with_pix;
        pix_data    = 4'd9;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = frame_pix[i][3:0];
            tick();
        end
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_writes(input string tag, input int n, input bit full);
        int cnt;
        cnt = wq_addr.size() - q_base;
        chk({tag, "_write_count"}, 0, cnt, n);
        for (int i = 0; i < n && i < cnt; i++) begin
            chk({tag, "_addr"}, i, wq_addr[q_base + i], i);
            chk({tag, "_data"}, i, wq_data[q_base + i], exp_ii[i]);
        end
        chk({tag, "_frame_done_count"}, 0, done_cnt - done_base, full ? 1 : 0);
        if (cnt > 0) chk({tag, "_frame_done_last"}, cnt - 1, wq_done[q_base + cnt - 1], full ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 0, wr_en, 0);
        chk({tag, "_wr_addr"}, 0, wr_addr, 0);
        chk({tag, "_wr_data"}, 0, wr_data, 0);
        chk({tag, "_busy"}, 0, busy, 0);
        chk({tag, "_frame_done"}, 0, frame_done, 0);
        chk({tag, "_overrun"}, 0, overrun, 0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 4'd0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Frame 1: all-15 with random gaps; pixel during frame_start is dropped
        for (int i = 0; i < N; i++) frame_pix[i] = 15;
        build_model();
        mark();
        start_frame(1'b1);
        chk("f1_busy_rise", 0, busy, 1);
        chk("f1_no_overrun_on_start", 0, overrun, 0);
        run_pixels(N, 10);
        drain();
        check_writes("f1", N, 1'b1);
        chk("f1_max_ii", 0, wq_data[q_base + N - 1], 288000);
        chk("f1_busy_fall", 0, busy, 0);

        // Three stray pixels after the frame completes
        mark();
        pix_valid = 1'b1; pix_data = 4'd5;
        repeat (3) tick();
        drain();
        chk("extra_write_count", 0, wq_addr.size() - q_base, 0);
        chk("extra_overrun", 0, overrun, 1);
        repeat (3) tick();
        chk("extra_overrun_sticky", 0, overrun, 1);

        // Frame 2: random pixels, restarted after 5000
        for (int i = 0; i < N; i++) frame_pix[i] = int'($urandom_range(15));
        build_model();
        mark();
        start_frame(1'b0);
        chk("f2_overrun_cleared", 0, overrun, 0);
        run_pixels(5000, 0);
        start_frame(1'b1);
        check_writes("f2_partial", 5000, 1'b0);
        chk("restart_overrun", 0, overrun, 0);
        chk("restart_busy", 0, busy, 1);

        // Frame 3: fresh random frame after the restart
        for (int i = 0; i < N; i++) frame_pix[i] = int'($urandom_range(15));
        build_model();
        mark();
        run_pixels(N, 0);
        drain();
        check_writes("f3", N, 1'b1);
        chk("restart_first_data", 0, wq_data[q_base], frame_pix[0]);

        // Frame 4: single 7 at (3,2), stale line buffer must not leak in
        for (int i = 0; i < N; i++) frame_pix[i] = 0;
        frame_pix[2*W + 3] = 7;
        build_model();
        mark();
        start_frame(1'b0);
        run_pixels(N, 0);
        drain();
        check_writes("f4", N, 1'b1);
        chk("f4_left_of_pixel", 0, wq_data[q_base + 2*W + 2], 0);
        chk("f4_above_pixel", 0, wq_data[q_base + 1*W + 159], 0);
        chk("f4_at_pixel", 0, wq_data[q_base + 2*W + 3], 7);
        chk("f4_corner", 0, wq_data[q_base + N - 1], 7);

        // Frame 5: all-ones, reset mid-row at (80,40)
        for (int i = 0; i < N; i++) frame_pix[i] = 1;
        build_model();
        mark();
        start_frame(1'b0);
        run_pixels(40*W + 80, 0);
        rst = 1'b1; pix_valid = 1'b1; pix_data = 4'd1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (3) tick();
        drain();
        check_writes("f5", 40*W + 80, 1'b0);
        chk("f5_addr159", 0, wq_data[q_base + 159], 160);
        chk("f5_addr160", 0, wq_data[q_base + 160], 2);
        chk("f5_overrun_after_rst", 0, overrun, 1);
        chk("f5_busy_after_rst", 0, busy, 0);
        start_frame(1'b0);
        chk("f5_overrun_cleared", 0, overrun, 0);
        chk("f5_busy_rearmed", 0, busy, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
